// File: rtl/wb_trace_buffer_pkg.sv
// Shared field widths and entry layout for the write-back trace buffer.
// Define WB_TRACE_PC_EN to store the committing PC alongside each entry.
package wb_trace_buffer_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef struct packed {
`ifdef WB_TRACE_PC_EN
        logic [PC_W-1:0]   pc;
`endif
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Drain-side valid/ready stream carrying the head trace entry.
interface wb_trace_buffer_if;
    import wb_trace_buffer_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [REG_W-1:0]  out_reg;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output out_valid,
        output out_reg,
        output out_data,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_reg,
        input  out_data,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/trace_fifo_ram.sv
// Trace storage: synchronous write port, asynchronous read port.
module trace_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures committed register writes into a show-ahead FIFO drained by valid/ready.
// WB_TRACE_PC_EN adds the committing PC to every entry and drives out_pc.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [REG_W-1:0]         wb_reg,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [PC_W-1:0]          wb_pc,
    input  logic                     freeze,
    input  logic                     clr_ovf,
    wb_trace_buffer_if.master        drain,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               empty;
    logic               full;
    logic               cap;
    logic               pop;
    logic               push;
    logic               drop;
    entry_t             wr_e;
    entry_t             rd_e;
    logic [ENTRY_W-1:0] rd_raw;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign cap  = wb_we && (wb_reg != ZERO_REG) && !freeze;
    assign pop  = !empty && drain.out_ready;
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

    always_comb begin
        wr_e      = '0;
        wr_e.rd   = wb_reg;
        wr_e.data = wb_data;
`ifdef WB_TRACE_PC_EN
        wr_e.pc   = wb_pc;
`endif
    end

    trace_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_e),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_raw)
    );

    assign rd_e = entry_t'(rd_raw);

    // RAM is never cleared, so the head is masked while nothing is valid
    assign drain.out_valid = !empty;
    assign drain.out_reg   = empty ? '0 : rd_e.rd;
    assign drain.out_data  = empty ? '0 : rd_e.data;
`ifdef WB_TRACE_PC_EN
    assign drain.out_pc    = empty ? '0 : rd_e.pc;
`else
    logic unused_pc;
    assign unused_pc       = ^wb_pc;
    assign drain.out_pc    = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A clear in the same cycle as a drop wins; that drop goes uncounted
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != CNT_MAX) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed vector table plus hand-written fill/drain sequences for wb_trace_buffer.
module tb_wb_trace_buffer;
    import wb_trace_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        freeze;
    logic        clr_ovf;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] drop_count;

    int tests = 0;
    int fails = 0;

    wb_trace_buffer_if bus ();

    wb_trace_buffer #(
        .DEPTH (16),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .wb_pc      (wb_pc),
        .freeze     (freeze),
        .clr_ovf    (clr_ovf),
        .drain      (bus.master),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rg;
        logic [31:0] data;
        logic [31:0] pc;
        logic        frz;
        logic        rdy;
        logic        e_valid;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic [4:0]  e_level;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wb_we   = 1'b0;
        wb_reg  = '0;
        wb_data = '0;
        wb_pc   = '0;
        freeze  = 1'b0;
        clr_ovf = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [4:0] r, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_reg  = r;
        wb_data = d;
        step();
        wb_we   = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        wb_we  = 1'b1;
        wb_reg = 5'd7;
        wb_data = 32'h1234;
        step();
        step();
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_cnt", 32'(drop_count), 0);
        chk("rst_data", bus.out_data, 0);
        idle();
        rst = 1'b1;
        step();

        //        we  rg    data          pc     frz rdy  v  reg   data         lvl
        vt[0] = '{1, 5'd8, 32'h0000_00A5, 32'h0, 0, 0,   1, 5'd8, 32'h0000_00A5, 5'd1};
        vt[1] = '{0, 5'd0, 32'h0,         32'h0, 0, 0,   1, 5'd8, 32'h0000_00A5, 5'd1};
        vt[2] = '{0, 5'd0, 32'h0,         32'h0, 0, 1,   0, 5'd0, 32'h0,         5'd0};
        vt[3] = '{1, 5'd0, 32'h0000_DEAD, 32'h0, 0, 0,   0, 5'd0, 32'h0,         5'd0};
        vt[4] = '{1, 5'd9, 32'h0000_0099, 32'h0, 1, 0,   0, 5'd0, 32'h0,         5'd0};
        vt[5] = '{1, 5'd3, 32'h0000_0007, 32'h40, 0, 0,  1, 5'd3, 32'h0000_0007, 5'd1};
        vt[6] = '{1, 5'd4, 32'h0000_0011, 32'h44, 0, 1,  1, 5'd4, 32'h0000_0011, 5'd1};
        vt[7] = '{0, 5'd0, 32'h0,         32'h0, 0, 1,   0, 5'd0, 32'h0,         5'd0};

        for (int i = 0; i < 8; i++) begin
            wb_we   = vt[i].we;
            wb_reg  = vt[i].rg;
            wb_data = vt[i].data;
            wb_pc   = vt[i].pc;
            freeze  = vt[i].frz;
            bus.out_ready = vt[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d_reg", i), 32'(bus.out_reg), 32'(vt[i].e_reg));
            chk($sformatf("v%0d_data", i), bus.out_data, vt[i].e_data);
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vt[i].e_level));
            if (i == 5) begin
`ifdef WB_TRACE_PC_EN
                chk("v5_pc", bus.out_pc, 32'h40);
`else
                chk("v5_pc", bus.out_pc, 32'h0);
`endif
            end
        end
        idle();

        // 18 pushes into a 16-deep FIFO: two drops
        for (int i = 1; i <= 18; i++) begin
            push1(5'(i), 32'h100 + 32'(i));
        end
        chk("full_level", 32'(level), 16);
        chk("full_ovf", 32'(overflow), 1);
        chk("full_cnt", 32'(drop_count), 2);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("drain%0d_reg", i), 32'(bus.out_reg), i);
            chk($sformatf("drain%0d_data", i), bus.out_data, 32'h100 + 32'(i));
            step();
        end
        bus.out_ready = 1'b0;
        chk("drained_level", 32'(level), 0);
        chk("drained_valid", 32'(bus.out_valid), 0);
        chk("drained_ovf", 32'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_cnt", 32'(drop_count), 0);

        // Full with simultaneous capture and pop
        for (int i = 1; i <= 16; i++) begin
            push1(5'(i), 32'h200 + 32'(i));
        end
        chk("refill_level", 32'(level), 16);
        bus.out_ready = 1'b1;
        push1(5'd20, 32'h999);
        bus.out_ready = 1'b0;
        chk("pp_level", 32'(level), 16);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_cnt", 32'(drop_count), 0);
        chk("pp_head", bus.out_data, 32'h202);

        // Clear beats a same-cycle drop, then a plain drop counts
        clr_ovf = 1'b1;
        push1(5'd21, 32'hAAA);
        clr_ovf = 1'b0;
        chk("clrdrop_ovf", 32'(overflow), 0);
        chk("clrdrop_cnt", 32'(drop_count), 0);
        push1(5'd22, 32'hBBB);
        chk("drop_ovf", 32'(overflow), 1);
        chk("drop_cnt", 32'(drop_count), 1);
        chk("drop_head", bus.out_data, 32'h202);

        // Drain past wrap: last entry must be the simultaneous push
        bus.out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        chk("last_data", bus.out_data, 32'h999);
        chk("last_reg", 32'(bus.out_reg), 20);
        chk("last_level", 32'(level), 1);
        bus.out_ready = 1'b0;

        // Reset mid-drain discards everything
        push1(5'd5, 32'h55);
        chk("pre_rst_level", 32'(level), 2);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_ovf", 32'(overflow), 0);
        chk("mid_rst_cnt", 32'(drop_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
